// File: rtl/memory_pkg.sv
// Shared encodings for the key/value cache write controller:
// FSM states, request opcodes and response status codes.
package memory_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_WRITE  = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  typedef enum logic {
    OP_PUT = 1'b0,
    OP_DEL = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    ST_OK        = 2'b00,
    ST_FULL      = 2'b01,
    ST_NOT_FOUND = 2'b10
  } status_e;

endpackage

// File: rtl/memory_write_controller_if.sv
// Request/response channel between a requester and the cache write controller.
interface memory_write_controller_if
  import memory_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned KEY_WIDTH   = 32,
  parameter int unsigned VALUE_WIDTH = 64
);
  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);

  logic                   req_valid;
  logic                   req_ready;
  op_e                    req_op;
  logic [KEY_WIDTH-1:0]   req_key;
  logic [VALUE_WIDTH-1:0] req_value;
  logic                   resp_valid;
  status_e                resp_status;
  logic [IDX_W-1:0]       resp_index;

  modport master (
    output req_valid, req_op, req_key, req_value,
    input  req_ready, resp_valid, resp_status, resp_index
  );

  modport slave (
    input  req_valid, req_op, req_key, req_value,
    output req_ready, resp_valid, resp_status, resp_index
  );

endinterface

// File: rtl/mem_priority_encoder.sv
// Lowest-set-bit search: returns the index of the least significant set bit
// and whether any bit was set (index is 0 when none).
module mem_priority_encoder #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] index,
  output logic             found
);

  always_comb begin
    index = '0;
    found = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (vec[i] && !found) begin
        index = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_write_controller.sv
// Cache write controller: looks up a key across register rows, then performs
// PUT (update/insert) or DEL (invalidate) and reports a one-cycle response.
module memory_write_controller
  import memory_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned KEY_WIDTH   = 32,
  parameter int unsigned VALUE_WIDTH = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  memory_write_controller_if.slave        bus,
  input  logic [NUM_ENTRIES*KEY_WIDTH-1:0] stored_keys,
  output logic [NUM_ENTRIES-1:0]          row_write,
  output logic [KEY_WIDTH-1:0]            wr_key,
  output logic [VALUE_WIDTH-1:0]          wr_value,
  output logic [NUM_ENTRIES-1:0]          valid_map
);

  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);

  state_e                 state, state_d;
  op_e                    lat_op, lat_op_d;
  logic [KEY_WIDTH-1:0]   lat_key, lat_key_d;
  logic [VALUE_WIDTH-1:0] lat_value, lat_value_d;
  logic [IDX_W-1:0]       target, target_d;
  logic [NUM_ENTRIES-1:0] valid_map_d;
  logic [NUM_ENTRIES-1:0] row_write_d;
  logic                   ready_q, ready_d;
  logic                   resp_valid_q, resp_valid_d;
  status_e                status_q, status_d;
  logic [IDX_W-1:0]       index_q, index_d;

  logic [NUM_ENTRIES-1:0] hit_vec;
  logic [IDX_W-1:0]       hit_idx, free_idx;
  logic                   hit_found, free_found;

  // Only occupied rows may match, so stale keys never hit
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      hit_vec[i] = valid_map[i] && (stored_keys[i*KEY_WIDTH +: KEY_WIDTH] == lat_key);
    end
  end

  mem_priority_encoder #(.WIDTH(NUM_ENTRIES)) u_hit_pe (
    .vec   (hit_vec),
    .index (hit_idx),
    .found (hit_found)
  );

  mem_priority_encoder #(.WIDTH(NUM_ENTRIES)) u_free_pe (
    .vec   (~valid_map),
    .index (free_idx),
    .found (free_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next state plus next value of every registered output
  always_comb begin
    state_d     = state;
    lat_op_d    = lat_op;
    lat_key_d   = lat_key;
    lat_value_d = lat_value;
    target_d    = target;
    valid_map_d = valid_map;
    status_d    = status_q;
    index_d     = index_q;
    unique case (state)
      S_IDLE: begin
        if (bus.req_valid && ready_q) begin
          lat_op_d    = bus.req_op;
          lat_key_d   = bus.req_key;
          lat_value_d = bus.req_value;
          state_d     = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (lat_op == OP_PUT) begin
          if (hit_found) begin
            target_d = hit_idx;
            state_d  = S_WRITE;
          end else if (free_found) begin
            target_d = free_idx;
            state_d  = S_WRITE;
          end else begin
            status_d = ST_FULL;
            index_d  = '0;
            state_d  = S_RESP;
          end
        end else if (hit_found) begin
          valid_map_d[hit_idx] = 1'b0;
          status_d = ST_OK;
          index_d  = hit_idx;
          state_d  = S_RESP;
        end else begin
          status_d = ST_NOT_FOUND;
          index_d  = '0;
          state_d  = S_RESP;
        end
      end
      S_WRITE: begin
        valid_map_d[target] = 1'b1;
        status_d = ST_OK;
        index_d  = target;
        state_d  = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d      = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
    row_write_d  = '0;
    if (state_d == S_WRITE) row_write_d[target_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_op       <= OP_PUT;
      lat_key      <= '0;
      lat_value    <= '0;
      target       <= '0;
      valid_map    <= '0;
      row_write    <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      status_q     <= ST_OK;
      index_q      <= '0;
    end else begin
      lat_op       <= lat_op_d;
      lat_key      <= lat_key_d;
      lat_value    <= lat_value_d;
      target       <= target_d;
      valid_map    <= valid_map_d;
      row_write    <= row_write_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      status_q     <= status_d;
      index_q      <= index_d;
    end
  end

  assign wr_key          = lat_key;
  assign wr_value        = lat_value;
  assign bus.req_ready   = ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_status = status_q;
  assign bus.resp_index  = index_q;

endmodule

// File: tb/tb_memory_write_controller.sv
// Directed bench for memory_write_controller with a 4-row key/value register model.
module tb_memory_write_controller;
  import memory_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned K  = 8;
  localparam int unsigned V  = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  memory_write_controller_if #(.NUM_ENTRIES(N), .KEY_WIDTH(K), .VALUE_WIDTH(V)) bus ();

  logic [N*K-1:0] stored_keys;
  logic [N-1:0]   row_write;
  logic [K-1:0]   wr_key;
  logic [V-1:0]   wr_value;
  logic [N-1:0]   valid_map;

  memory_write_controller #(.NUM_ENTRIES(N), .KEY_WIDTH(K), .VALUE_WIDTH(V)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .stored_keys (stored_keys),
    .row_write   (row_write),
    .wr_key      (wr_key),
    .wr_value    (wr_value),
    .valid_map   (valid_map)
  );

  // Register rows capture on the negedge of the write cycle
  logic [K-1:0] kmem [N];
  logic [V-1:0] vmem [N];
  always @(negedge clk) begin
    for (int i = 0; i < int'(N); i++) begin
      if (row_write[i]) begin
        kmem[i] <= wr_key;
        vmem[i] <= wr_value;
      end
    end
  end
  always_comb begin
    for (int i = 0; i < int'(N); i++) stored_keys[i*K +: K] = kmem[i];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        op;
    logic [7:0]  key;
    logic [15:0] value;
    logic        hold;
    logic [3:0]  exp_rw;
    logic [1:0]  exp_st;
    logic [1:0]  exp_idx;
    logic [3:0]  exp_vmap;
    int          exp_lat;
  } vec_t;

  vec_t tbl [14];

  task automatic run_req(input vec_t v, input int n);
    int         lat;
    int         rw_cyc;
    logic [3:0] rw_or;
    logic [1:0] st;
    logic [1:0] idx;
    logic [3:0] vm;
    logic       rdy;
    logic [7:0] wk_seen;
    string      t;
    t = $sformatf("v%0d", n);
    @(negedge clk);
    chk({t, " ready_idle"}, 32'(bus.req_ready), 32'd1);
    chk({t, " resp_pulse_end"}, 32'(bus.resp_valid), 32'd0);
    bus.req_valid = 1'b1;
    bus.req_op    = op_e'(v.op);
    bus.req_key   = v.key;
    bus.req_value = v.value;
    @(posedge clk);
    #1;
    if (v.hold) begin
      bus.req_key   = ~v.key;
      bus.req_value = ~v.value;
    end else begin
      bus.req_valid = 1'b0;
    end
    lat = 0; rw_cyc = 0; rw_or = '0; st = '0; idx = '0; vm = '0; rdy = 1'b1; wk_seen = v.key;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      rw_or = rw_or | row_write;
      if (row_write != '0) begin
        rw_cyc++;
        wk_seen = wr_key;
      end
      if (bus.resp_valid) begin
        lat = c;
        st  = bus.resp_status;
        idx = bus.resp_index;
        vm  = valid_map;
        rdy = bus.req_ready;
      end
    end
    bus.req_valid = 1'b0;
    chk({t, " latency"}, 32'(lat), 32'(v.exp_lat));
    chk({t, " row_write"}, 32'(rw_or), 32'(v.exp_rw));
    chk({t, " write_cycles"}, 32'(rw_cyc), (v.exp_rw != '0) ? 32'd1 : 32'd0);
    chk({t, " status"}, 32'(st), 32'(v.exp_st));
    chk({t, " index"}, 32'(idx), 32'(v.exp_idx));
    chk({t, " valid_map"}, 32'(vm), 32'(v.exp_vmap));
    chk({t, " ready_busy"}, 32'(rdy), 32'd0);
    if (v.exp_rw != '0) begin
      chk({t, " wr_key"}, 32'(wk_seen), 32'(v.key));
      chk({t, " row_key"}, 32'(kmem[v.exp_idx]), 32'(v.key));
      chk({t, " row_value"}, 32'(vmem[v.exp_idx]), 32'(v.value));
    end
  endtask

  initial begin
    //           op  key    value     hold rw       st     idx   vmap     lat
    tbl[0]  = '{1'b0, 8'h11, 16'hBEEF, 1'b0, 4'b0001, 2'b00, 2'd0, 4'b0001, 3};
    tbl[1]  = '{1'b0, 8'h11, 16'hCAFE, 1'b0, 4'b0001, 2'b00, 2'd0, 4'b0001, 3};
    tbl[2]  = '{1'b0, 8'h22, 16'h2222, 1'b0, 4'b0010, 2'b00, 2'd1, 4'b0011, 3};
    tbl[3]  = '{1'b0, 8'h33, 16'h3333, 1'b0, 4'b0100, 2'b00, 2'd2, 4'b0111, 3};
    tbl[4]  = '{1'b0, 8'h44, 16'h4444, 1'b0, 4'b1000, 2'b00, 2'd3, 4'b1111, 3};
    tbl[5]  = '{1'b0, 8'h55, 16'h5555, 1'b0, 4'b0000, 2'b01, 2'd0, 4'b1111, 2};
    tbl[6]  = '{1'b1, 8'h33, 16'h0000, 1'b0, 4'b0000, 2'b00, 2'd2, 4'b1011, 2};
    tbl[7]  = '{1'b0, 8'h66, 16'h6666, 1'b1, 4'b0100, 2'b00, 2'd2, 4'b1111, 3};
    tbl[8]  = '{1'b1, 8'h99, 16'h0000, 1'b0, 4'b0000, 2'b10, 2'd0, 4'b1111, 2};
    tbl[9]  = '{1'b1, 8'h11, 16'h0000, 1'b1, 4'b0000, 2'b00, 2'd0, 4'b1110, 2};
    tbl[10] = '{1'b1, 8'h22, 16'h0000, 1'b0, 4'b0000, 2'b00, 2'd1, 4'b1100, 2};
    tbl[11] = '{1'b1, 8'h22, 16'h0000, 1'b0, 4'b0000, 2'b10, 2'd0, 4'b1100, 2};
    tbl[12] = '{1'b0, 8'h77, 16'h7777, 1'b0, 4'b0001, 2'b00, 2'd0, 4'b1101, 3};
    // After a reset row 2 still holds 0x66, but it is unoccupied
    tbl[13] = '{1'b0, 8'h66, 16'hD00D, 1'b0, 4'b0001, 2'b00, 2'd0, 4'b0001, 3};

    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = OP_PUT;
    bus.req_key   = '0;
    bus.req_value = '0;
    #12;
    chk("rst row_write", 32'(row_write), 32'd0);
    chk("rst valid_map", 32'(valid_map), 32'd0);
    chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst resp_status", 32'(bus.resp_status), 32'd0);
    chk("rst resp_index", 32'(bus.resp_index), 32'd0);
    chk("rst wr_key", 32'(wr_key), 32'd0);
    chk("rst wr_value", 32'(wr_value), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst ready", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < 13; i++) run_req(tbl[i], i);

    // Reset asserted in the middle of a WRITE cycle
    begin
      int seen;
      seen = 0;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = OP_PUT;
      bus.req_key   = 8'h88;
      bus.req_value = 16'h8888;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      for (int c = 0; c < 6 && seen == 0; c++) begin
        @(negedge clk);
        if (row_write != '0) seen = 1;
      end
      chk("midrst write_seen", 32'(row_write), 32'b0010);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst row_write", 32'(row_write), 32'd0);
      chk("midrst valid_map", 32'(valid_map), 32'd0);
      chk("midrst resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("midrst ready", 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("midrst ready_release", 32'(bus.req_ready), 32'd1);
    end

    run_req(tbl[13], 13);

    @(negedge clk);
    chk("final resp_idle", 32'(bus.resp_valid), 32'd0);
    chk("final row_write_idle", 32'(row_write), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_write_controller.md
MEMORY_WRITE_CONTROLLER -- requirements
Module: memory_write_controller

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 8, number of cache rows (>=2).
REQ-002 SHALL have parameter KEY_WIDTH, default 32, key bits per row.
REQ-003 SHALL have parameter VALUE_WIDTH, default 64, value bits per row.
REQ-004 SHALL have port clk, input, 1, single clock; controller logic on posedge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid, input, 1, request present.
REQ-007 SHALL have port req_ready, output, 1, request accepted when req_valid&req_ready at posedge.
REQ-008 SHALL have port req_op, input, 1, 0=PUT, 1=DEL.
REQ-009 SHALL have port req_key, input, KEY_WIDTH, request key.
REQ-010 SHALL have port req_value, input, VALUE_WIDTH, PUT value; ignored for DEL.
REQ-011 SHALL have port stored_keys, input, NUM_ENTRIES*KEY_WIDTH, key row data_out values, row i at bits [i*KEY_WIDTH +: KEY_WIDTH].
REQ-012 SHALL have port row_write, output, NUM_ENTRIES, one-hot write_op to the key and value register rows.
REQ-013 SHALL have port wr_key, output, KEY_WIDTH, data_in for key rows.
REQ-014 SHALL have port wr_value, output, VALUE_WIDTH, data_in for value rows.
REQ-015 SHALL have port valid_map, output, NUM_ENTRIES, bit i set = row i occupied.
REQ-016 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-017 SHALL have port resp_status, output, 2, 00 OK, 01 FULL, 10 NOT_FOUND.
REQ-018 SHALL have port resp_index, output, $clog2(NUM_ENTRIES), row written or deleted; 0 when status not OK.

Function
REQ-019 SHALL implement FSM IDLE, LOOKUP, WRITE, RESP; req_ready=1 only in IDLE.
REQ-020 IDLE: on handshake SHALL latch op/key/value into internal registers and go to LOOKUP; otherwise stay.
REQ-021 LOOKUP: hit vector = valid_map & (stored_keys row == latched key); hit index = lowest set bit; free index = lowest clear bit of valid_map.
REQ-022 PUT hit -> target=hit index, go WRITE; PUT miss with free row -> target=free index, go WRITE; PUT miss, no free row -> status FULL, go RESP.
REQ-023 DEL hit -> clear valid_map[hit index] at the LOOKUP-exit edge, status OK, go RESP; DEL miss -> status NOT_FOUND, go RESP; DEL SHALL never assert row_write.
REQ-024 WRITE: row_write SHALL equal one-hot(target) for exactly that one cycle, wr_key/wr_value driven from latched registers the whole cycle so rows capture on the mid-cycle negedge; set valid_map[target] at the WRITE-exit edge; status OK; go RESP.
REQ-025 row_write SHALL be zero in every state except WRITE; wr_key/wr_value SHALL hold the latched request at all times.
REQ-026 RESP: resp_valid=1, resp_status/resp_index stable for that cycle; next state IDLE.
REQ-027 Latency: PUT with write = resp_valid in 3rd cycle after accept; FULL/DEL = 2nd cycle; back-to-back accept possible in cycle after RESP.
REQ-028 req_valid while req_ready=0 SHALL be ignored; requester holds the request.
REQ-029 Stale keys in rows with valid_map bit clear SHALL never produce a hit.

Reset
REQ-030 rst_n low SHALL asynchronously force state IDLE, valid_map 0, row_write 0, resp_valid 0, resp_status 00, resp_index 0, latched registers 0; applies mid-operation, aborting any WRITE.
REQ-031 After rst_n release, req_ready SHALL be 1 in the first cycle.

Structure
REQ-032 Shared package memory_pkg SHALL hold the state enum, the req_op encoding and the resp_status encoding.
REQ-033 Lowest-set-bit search SHALL be one sub-module mem_priority_encoder (NUM_ENTRIES in, index + found out), instantiated twice (hit, free).

Verification (NUM_ENTRIES=4, KEY_WIDTH=8, VALUE_WIDTH=16)
REQ-034 PUT key 0x11 value 0xBEEF after reset -> row_write 0001 one cycle, resp OK index 0, valid_map 0001.
REQ-035 PUT 0x11 again with 0xCAFE -> row_write 0001, index 0, valid_map unchanged 0001.
REQ-036 Fill 4 distinct keys, then PUT 0x55 -> no row_write, resp FULL index 0, valid_map 1111.
REQ-037 DEL key in row 2 -> no row_write, resp OK index 2, valid_map 1011; next PUT new key -> row 2 written.
REQ-038 DEL absent key 0x99 -> resp NOT_FOUND, valid_map unchanged.
REQ-039 Assert rst_n low during WRITE -> row_write drops immediately, valid_map 0000, req_ready 1 after release.
